// File: rtl/crossy_pkg.sv
// Shared types for the road lane logic: scheduler state encoding and the
// per-lane shift-rate divisor.
package crossy_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_PAUSED,
      S_HALT
   } sched_state_t;

   // Lanes repeat a 1,2,3,4 rate pattern across the road.
   function automatic logic [2:0] lane_div(input int i);
      return 3'((i % 4) + 1);
   endfunction

endpackage

// File: rtl/lane_scheduler_if.sv
// Control/shift bus between the game FSM, the lane scheduler and the shifters.
interface lane_scheduler_if #(
   parameter int NUM_LANES = 8,
   parameter int LEVEL_W   = 3
);
   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic                 start;
   logic                 pause;
   logic                 level_up;
   logic                 game_over;
   logic [NUM_LANES-1:0] lane_load;
   logic [IDX_W-1:0]     load_idx;
   logic [NUM_LANES-1:0] lane_enable;
   logic [LEVEL_W-1:0]   level;
   logic                 running;

   modport master (
      output start, pause, level_up, game_over,
      input  lane_load, load_idx, lane_enable, level, running
   );

   modport slave (
      input  start, pause, level_up, game_over,
      output lane_load, load_idx, lane_enable, level, running
   );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running 0..period-1 counter producing a one-cycle tick on the last count;
// clear restarts from 0, hold freezes the count and suppresses the tick.
module tick_prescaler #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] period,
   input  logic             clear,
   input  logic             hold,
   output logic             tick
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // >= keeps the counter from running away if the period ever shrinks under it.
   assign tick = !hold && !clear && (cnt_q >= period - CNT_W'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (!hold)
         cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/lane_scheduler.sv
// Loads lane patterns one lane per cycle, then paces per-lane shift enables
// from a level-scaled prescaler.
//
//   state    | meaning
//   S_IDLE   | waiting for start, all outputs low
//   S_LOAD   | pulsing lane_load one lane per cycle
//   S_RUN    | prescaler running, lane enables issued
//   S_PAUSED | counters frozen, level_up still accepted
//   S_HALT   | game over, everything frozen until start
module lane_scheduler
   import crossy_pkg::*;
#(
   parameter int NUM_LANES   = 8,
   parameter int CNT_W       = 24,
   parameter int BASE_PERIOD = 6_250_000,
   parameter int LEVEL_W     = 3,
   parameter int MAX_LEVEL   = 5
) (
   input  logic            clk,
   input  logic            reset,
   lane_scheduler_if.slave bus
);
   localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   sched_state_t                state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [LEVEL_W-1:0]          level_q, level_d;
   logic [NUM_LANES-1:0][1:0]   sub_q, sub_d;
   logic [NUM_LANES-1:0]        lane_load_q, lane_load_d;
   logic [NUM_LANES-1:0]        lane_enable_q, lane_enable_d;
   logic [IDX_W-1:0]            load_idx_q, load_idx_d;
   logic                        running_q, running_d;

   logic [CNT_W-1:0] base_shift, period;
   logic             tick, pre_clear, pre_hold, lvl_apply;

   // Clamp so an over-shifted base still ticks every cycle.
   assign base_shift = CNT_W'(BASE_PERIOD) >> level_q;
   assign period     = (base_shift == '0) ? CNT_W'(1) : base_shift;

   assign lvl_apply = bus.level_up && !bus.game_over &&
                      ((state_q == S_RUN && !bus.pause) || state_q == S_PAUSED);
   assign pre_hold  = (state_q != S_RUN) || bus.game_over || bus.pause;
   assign pre_clear = (state_q == S_LOAD) || lvl_apply;

   tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .period (period),
      .clear  (pre_clear),
      .hold   (pre_hold),
      .tick   (tick)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      level_d       = level_q;
      sub_d         = sub_q;
      lane_enable_d = '0;
      lane_load_d   = '0;
      load_idx_d    = '0;

      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               state_d = S_LOAD;
               idx_d   = '0;
               level_d = '0;
               sub_d   = '0;
            end
         end
         S_LOAD: begin
            if (idx_q == IDX_W'(NUM_LANES - 1))
               state_d = S_RUN;
            else
               idx_d = idx_q + IDX_W'(1);
         end
         S_RUN: begin
            if (bus.game_over)
               state_d = S_HALT;
            else if (bus.pause)
               state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (bus.game_over)
               state_d = S_HALT;
            else if (!bus.pause)
               state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase

      if (lvl_apply && level_q < LEVEL_W'(MAX_LEVEL))
         level_d = level_q + LEVEL_W'(1);

      // tick is already masked by every higher-priority event.
      if (tick) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (sub_q[i] == 2'(lane_div(i) - 3'd1)) begin
               lane_enable_d[i] = 1'b1;
               sub_d[i]         = '0;
            end else begin
               sub_d[i] = sub_q[i] + 2'd1;
            end
         end
      end

      if (state_d == S_LOAD) begin
         lane_load_d[idx_d] = 1'b1;
         load_idx_d         = idx_d;
      end
      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         level_q       <= '0;
         sub_q         <= '0;
         lane_load_q   <= '0;
         lane_enable_q <= '0;
         load_idx_q    <= '0;
         running_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         level_q       <= level_d;
         sub_q         <= sub_d;
         lane_load_q   <= lane_load_d;
         lane_enable_q <= lane_enable_d;
         load_idx_q    <= load_idx_d;
         running_q     <= running_d;
      end
   end

   assign bus.lane_load   = lane_load_q;
   assign bus.load_idx    = load_idx_q;
   assign bus.lane_enable = lane_enable_q;
   assign bus.level       = level_q;
   assign bus.running     = running_q;
endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler with 4 lanes and a base period of 16.
module tb_lane_scheduler;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   lane_scheduler_if #(.NUM_LANES(4), .LEVEL_W(3)) bus ();

   lane_scheduler #(
      .NUM_LANES   (4),
      .CNT_W       (24),
      .BASE_PERIOD (16),
      .LEVEL_W     (3),
      .MAX_LEVEL   (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [3:0] exp_en;
      int         p;

      bus.start     = 1'b0;
      bus.pause     = 1'b0;
      bus.level_up  = 1'b0;
      bus.game_over = 1'b0;

      step(2);
      reset = 1'b0;
      step(1);
      chk("rst_running", bus.running, 0);
      chk("rst_lane_load", bus.lane_load, 0);
      chk("rst_lane_enable", bus.lane_enable, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_load_idx", bus.load_idx, 0);

      // start -> one-hot load sweep
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("load_onehot", bus.lane_load, 32'(1 << i));
         chk("load_idx", bus.load_idx, 32'(i));
         chk("load_not_running", bus.running, 0);
         step(1);
      end
      chk("run_entry_running", bus.running, 1);
      chk("run_entry_load_clear", bus.lane_load, 0);

      // 64 cycles at level 0: lane i fires every 16*(i+1) cycles
      for (int c = 1; c <= 64; c++) begin
         step(1);
         exp_en = '0;
         for (int i = 0; i < 4; i++)
            if (c % (16 * (i + 1)) == 0) exp_en[i] = 1'b1;
         chk("run_lane_enable", bus.lane_enable, exp_en);
      end

      // start in RUN is ignored
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("start_ignored_running", bus.running, 1);
      chk("start_ignored_load", bus.lane_load, 0);
      step(4);

      // pause with prescaler at count 5 for 20 cycles
      bus.pause = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         chk("pause_no_enable", bus.lane_enable, 0);
         chk("pause_not_running", bus.running, 0);
      end
      bus.pause = 1'b0;
      step(1);
      chk("resume_running", bus.running, 1);
      for (int k = 1; k <= 11; k++) begin
         step(1);
         chk("resume_remaining", bus.lane_enable, (k == 11) ? 32'h1 : 32'h0);
      end

      // level_up x6: saturates at 5, lane0 period follows immediately
      for (int j = 1; j <= 6; j++) begin
         p = (j >= 4) ? 1 : (16 >> j);
         bus.level_up = 1'b1;
         step(1);
         bus.level_up = 1'b0;
         chk("level_value", bus.level, (j > 5) ? 32'd5 : 32'(j));
         chk("level_no_stale_enable", bus.lane_enable[0], 0);
         for (int k = 1; k <= p; k++) begin
            step(1);
            chk("level_period", bus.lane_enable[0], 32'(k == p));
         end
      end

      // game_over with pause in the same cycle -> HALT
      bus.game_over = 1'b1;
      bus.pause     = 1'b1;
      step(1);
      bus.game_over = 1'b0;
      bus.pause     = 1'b0;
      chk("halt_running", bus.running, 0);
      chk("halt_no_enable", bus.lane_enable, 0);
      chk("halt_level_held", bus.level, 5);
      step(3);
      chk("halt_stays", bus.running, 0);
      chk("halt_stays_no_enable", bus.lane_enable, 0);

      // restart from HALT
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      chk("restart_level", bus.level, 0);
      for (int i = 0; i < 4; i++) begin
         chk("restart_onehot", bus.lane_load, 32'(1 << i));
         chk("restart_idx", bus.load_idx, 32'(i));
         step(1);
      end
      chk("restart_running", bus.running, 1);

      bus.level_up = 1'b1;
      step(1);
      bus.level_up = 1'b0;
      chk("restart_level_up", bus.level, 1);
      step(3);
      chk("pre_reset_running", bus.running, 1);

      // asynchronous reset between edges
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_running", bus.running, 0);
      chk("async_rst_level", bus.level, 0);
      chk("async_rst_lane_load", bus.lane_load, 0);
      chk("async_rst_lane_enable", bus.lane_enable, 0);
      chk("async_rst_load_idx", bus.load_idx, 0);
      step(1);
      reset = 1'b0;
      step(2);
      chk("post_rst_idle_running", bus.running, 0);
      chk("post_rst_idle_load", bus.lane_load, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
